// File: rtl/decode_dispatch.sv
// RV32I decode/dispatch stage: a small instruction queue whose head is decoded into the
// 6-bit op encoding and dispatched with a wrapping ROB tag when ROB, RS and (for memory ops) LSB have space.
module decode_dispatch #(
    parameter int ROB_WIDTH = 4,
    parameter int IQ_WIDTH  = 2,
    parameter int IQ_DEPTH  = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 if_valid,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_inst,
    output logic                 if_ready,
    input  logic                 rob_ready,
    input  logic                 rs_ready,
    input  logic                 lsb_ready,
    output logic                 out_valid,
    output logic                 out_to_rs,
    output logic                 out_to_lsb,
    output logic [5:0]           out_op,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [31:0]          out_imm,
    output logic [31:0]          out_pc,
    output logic [ROB_WIDTH-1:0] out_tag,
    output logic                 out_illegal,
    output logic [IQ_WIDTH:0]    iq_count
);

    localparam logic [5:0] OP_NOTHING = 6'd37;
    localparam logic [IQ_WIDTH:0] IQ_FULL = (IQ_WIDTH+1)'(IQ_DEPTH);

    logic [31:0]          inst_q [IQ_DEPTH];
    logic [31:0]          pc_q   [IQ_DEPTH];
    logic [IQ_WIDTH-1:0]  head_q, tail_q;
    logic [IQ_WIDTH:0]    count_q, count_d;
    logic [ROB_WIDTH-1:0] tag_q;

    logic                 valid_q, to_rs_q, to_lsb_q, illegal_q;
    logic [5:0]           op_q;
    logic [4:0]           rd_q, rs1_q, rs2_q;
    logic [31:0]          imm_q, opc_q;
    logic [ROB_WIDTH-1:0] otag_q;

    logic [31:0] inst;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [5:0]  dec_op;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic        dec_mem;
    logic        enq, dispatch;

    assign inst   = inst_q[head_q];
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    always_comb begin
        dec_op  = OP_NOTHING;
        dec_imm = 32'd0;
        dec_rd  = inst[11:7];
        dec_mem = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: dec_op = 6'd0;
                        3'b001: dec_op = 6'd5;
                        3'b010: dec_op = 6'd8;
                        3'b011: dec_op = 6'd9;
                        3'b100: dec_op = 6'd4;
                        3'b101: dec_op = 6'd6;
                        3'b110: dec_op = 6'd3;
                        default: dec_op = 6'd2;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000) dec_op = 6'd1;
                    else if (f3 == 3'b101) dec_op = 6'd7;
                end
            end
            7'b0010011: begin
                dec_imm = {{20{inst[31]}}, inst[31:20]};
                case (f3)
                    3'b000: dec_op = 6'd10;
                    3'b111: dec_op = 6'd11;
                    3'b110: dec_op = 6'd12;
                    3'b100: dec_op = 6'd13;
                    3'b010: dec_op = 6'd17;
                    3'b011: dec_op = 6'd18;
                    3'b001: if (f7 == 7'b0000000) dec_op = 6'd14;
                    default: begin
                        if (f7 == 7'b0000000) dec_op = 6'd15;
                        else if (f7 == 7'b0100000) dec_op = 6'd16;
                    end
                endcase
                if (f3 == 3'b001 || f3 == 3'b101) dec_imm = {27'd0, inst[24:20]};
            end
            7'b0000011: begin
                dec_imm = {{20{inst[31]}}, inst[31:20]};
                dec_mem = 1'b1;
                case (f3)
                    3'b000: dec_op = 6'd19;
                    3'b100: dec_op = 6'd20;
                    3'b001: dec_op = 6'd21;
                    3'b101: dec_op = 6'd22;
                    3'b010: dec_op = 6'd23;
                    default: dec_op = OP_NOTHING;
                endcase
            end
            7'b0100011: begin
                dec_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec_rd  = 5'd0;
                dec_mem = 1'b1;
                case (f3)
                    3'b000: dec_op = 6'd24;
                    3'b001: dec_op = 6'd25;
                    3'b010: dec_op = 6'd26;
                    default: dec_op = OP_NOTHING;
                endcase
            end
            7'b1100011: begin
                dec_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                dec_rd  = 5'd0;
                case (f3)
                    3'b000: dec_op = 6'd27;
                    3'b101: dec_op = 6'd28;
                    3'b111: dec_op = 6'd29;
                    3'b100: dec_op = 6'd30;
                    3'b110: dec_op = 6'd31;
                    3'b001: dec_op = 6'd32;
                    default: dec_op = OP_NOTHING;
                endcase
            end
            7'b1101111: begin
                dec_op  = 6'd33;
                dec_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_imm = {{20{inst[31]}}, inst[31:20]};
                if (f3 == 3'b000) dec_op = 6'd34;
            end
            7'b0010111: begin
                dec_op  = 6'd35;
                dec_imm = {inst[31:12], 12'd0};
            end
            7'b0110111: begin
                dec_op  = 6'd36;
                dec_imm = {inst[31:12], 12'd0};
            end
            default: dec_op = OP_NOTHING;
        endcase
        // Illegal words go to RS only, with a clean immediate, so the ROB can trap in order.
        if (dec_op == OP_NOTHING) begin
            dec_imm = 32'd0;
            dec_mem = 1'b0;
        end
    end

    assign if_ready = (count_q != IQ_FULL) && !clear;
    assign enq      = if_valid && if_ready;
    assign dispatch = (count_q != '0) && rob_ready && rs_ready && (!dec_mem || lsb_ready) && !clear;

    always_comb begin
        count_d = count_q;
        case ({enq, dispatch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                inst_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
            head_q <= '0; tail_q <= '0; count_q <= '0; tag_q <= '0;
            valid_q <= 1'b0; to_rs_q <= 1'b0; to_lsb_q <= 1'b0; illegal_q <= 1'b0;
            op_q <= OP_NOTHING; rd_q <= '0; rs1_q <= '0; rs2_q <= '0;
            imm_q <= '0; opc_q <= '0; otag_q <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                head_q <= '0; tail_q <= '0; count_q <= '0; tag_q <= '0;
                valid_q <= 1'b0; to_rs_q <= 1'b0; to_lsb_q <= 1'b0;
            end else begin
                valid_q  <= dispatch;
                to_rs_q  <= dispatch;
                to_lsb_q <= dispatch && dec_mem;
                count_q  <= count_d;
                if (dispatch) begin
                    op_q      <= dec_op;
                    illegal_q <= (dec_op == OP_NOTHING);
                    rd_q      <= dec_rd;
                    rs1_q     <= inst[19:15];
                    rs2_q     <= inst[24:20];
                    imm_q     <= dec_imm;
                    opc_q     <= pc_q[head_q];
                    otag_q    <= tag_q;
                    tag_q     <= tag_q + 1'b1;
                    head_q    <= head_q + 1'b1;
                end
                if (enq) begin
                    inst_q[tail_q] <= if_inst;
                    pc_q[tail_q]   <= if_pc;
                    tail_q         <= tail_q + 1'b1;
                end
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_to_rs   = to_rs_q;
    assign out_to_lsb  = to_lsb_q;
    assign out_op      = op_q;
    assign out_rd      = rd_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_imm     = imm_q;
    assign out_pc      = opc_q;
    assign out_tag     = otag_q;
    assign out_illegal = illegal_q;
    assign iq_count    = count_q;

endmodule

// File: tb/tb_decode_dispatch.sv
// Directed bench for decode_dispatch: queueing, decode, tag wrap, flush, hold and async reset.
module tb_decode_dispatch;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, if_valid;
    logic [31:0] if_pc, if_inst;
    logic        if_ready, rob_ready, rs_ready, lsb_ready;
    logic        out_valid, out_to_rs, out_to_lsb, out_illegal;
    logic [5:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc;
    logic [3:0]  out_tag;
    logic [2:0]  iq_count;

    int n_tests = 0;
    int n_fail  = 0;

    decode_dispatch #(.ROB_WIDTH(4), .IQ_WIDTH(2), .IQ_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .rob_ready(rob_ready), .rs_ready(rs_ready), .lsb_ready(lsb_ready),
        .out_valid(out_valid), .out_to_rs(out_to_rs), .out_to_lsb(out_to_lsb),
        .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_pc(out_pc), .out_tag(out_tag),
        .out_illegal(out_illegal), .iq_count(iq_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_valid = 1'b0;
        if_pc = 32'd0; if_inst = 32'd0;
        rob_ready = 1'b1; rs_ready = 1'b1; lsb_ready = 1'b1;
        tick(); tick();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({out_valid, out_to_rs, out_to_lsb, out_illegal} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, out_to_rs, out_to_lsb, out_illegal});
        end
        n_tests++;
        if (out_op !== 6'd37) begin n_fail++; $display("FAIL reset_op got=%0d exp=37", out_op); end
        n_tests++;
        if ({out_rd, out_rs1, out_rs2, out_imm, out_pc, out_tag, iq_count} !== '0) begin
            n_fail++; $display("FAIL reset_data got imm=%h pc=%h tag=%0d cnt=%0d", out_imm, out_pc, out_tag, iq_count);
        end
        n_tests++;
        if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
    endtask

    task automatic test_addi();
        do_reset();
        if_valid = 1'b1; if_inst = 32'hFFB00093; if_pc = 32'h0000_0100;
        tick();
        if_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || iq_count !== 3'd1) begin
            n_fail++; $display("FAIL addi_enq got valid=%b cnt=%0d exp valid=0 cnt=1", out_valid, iq_count);
        end
        tick();
        n_tests++;
        if ({out_valid, out_to_rs, out_to_lsb, out_op, out_rd, out_rs1, out_imm, out_tag, out_pc}
            !== {1'b1, 1'b1, 1'b0, 6'd10, 5'd1, 5'd0, 32'hFFFFFFFB, 4'd0, 32'h100}) begin
            n_fail++; $display("FAIL addi_dispatch got v=%b lsb=%b op=%0d rd=%0d imm=%h tag=%0d pc=%h",
                               out_valid, out_to_lsb, out_op, out_rd, out_imm, out_tag, out_pc);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_to_rs !== 1'b0 || out_op !== 6'd10 || out_imm !== 32'hFFFFFFFB) begin
            n_fail++; $display("FAIL addi_pulse got v=%b rs=%b op=%0d imm=%h exp v=0 rs=0 op=10", out_valid, out_to_rs, out_op, out_imm);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        rob_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_inst = (i << 20) | ((i + 1) << 7) | 32'h13; if_pc = 32'h200 + 4 * i;
            tick();
        end
        if_valid = 1'b1;
        n_tests++;
        if (iq_count !== 3'd4 || if_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%b v=%b exp cnt=4 rdy=0 v=0", iq_count, if_ready, out_valid);
        end
        rob_ready = 1'b1;
        #1;
        n_tests++;
        if (if_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got if_ready=%b exp=0", if_ready); end
        if_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_tag !== 4'(i) || out_rd !== 5'(i + 1) || out_imm !== 32'(i)
                || out_pc !== 32'(32'h200 + 4 * i) || iq_count !== 3'(3 - i)) begin
                n_fail++; $display("FAIL drain_%0d got v=%b tag=%0d rd=%0d imm=%h pc=%h cnt=%0d exp tag=%0d rd=%0d cnt=%0d",
                                   i, out_valid, out_tag, out_rd, out_imm, out_pc, iq_count, i, i + 1, 3 - i);
            end
        end
    endtask

    task automatic test_store_lsb();
        do_reset();
        lsb_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h0020A423; if_pc = 32'h300;
        tick();
        if_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || iq_count !== 3'd1) begin
            n_fail++; $display("FAIL store_blocked got v=%b cnt=%0d exp v=0 cnt=1", out_valid, iq_count);
        end
        lsb_ready = 1'b1;
        tick();
        n_tests++;
        if ({out_valid, out_to_rs, out_to_lsb, out_op, out_rd, out_rs1, out_rs2, out_imm}
            !== {1'b1, 1'b1, 1'b1, 6'd26, 5'd0, 5'd1, 5'd2, 32'd8}) begin
            n_fail++; $display("FAIL store_dispatch got v=%b rs=%b lsb=%b op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h",
                               out_valid, out_to_rs, out_to_lsb, out_op, out_rd, out_rs1, out_rs2, out_imm);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        if_valid = 1'b1; if_inst = 32'h002081B3;
        tick();
        for (int k = 0; k < 17; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_tag !== 4'(k % 16) || out_op !== 6'd0 || out_rd !== 5'd3 || iq_count !== 3'd1) begin
                n_fail++; $display("FAIL b2b_%0d got v=%b tag=%0d op=%0d rd=%0d cnt=%0d exp tag=%0d op=0 rd=3 cnt=1",
                                   k, out_valid, out_tag, out_op, out_rd, iq_count, k % 16);
            end
        end
        if_valid = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] insts [9];
        logic [5:0]  ops   [9];
        logic [31:0] imms  [9];
        logic [1:0]  flags [9];
        insts[0] = 32'h402081B3; ops[0] = 6'd1;  imms[0] = 32'h0;        flags[0] = 2'b00;
        insts[1] = 32'h202081B3; ops[1] = 6'd37; imms[1] = 32'h0;        flags[1] = 2'b10;
        insts[2] = 32'h4030D093; ops[2] = 6'd16; imms[2] = 32'h3;        flags[2] = 2'b00;
        insts[3] = 32'hFFFFFFFF; ops[3] = 6'd37; imms[3] = 32'h0;        flags[3] = 2'b10;
        insts[4] = 32'hFFDFF0EF; ops[4] = 6'd33; imms[4] = 32'hFFFFFFFC; flags[4] = 2'b00;
        insts[5] = 32'h123452B7; ops[5] = 6'd36; imms[5] = 32'h12345000; flags[5] = 2'b00;
        insts[6] = 32'hFE208CE3; ops[6] = 6'd27; imms[6] = 32'hFFFFFFF8; flags[6] = 2'b00;
        insts[7] = 32'hFFC0A283; ops[7] = 6'd23; imms[7] = 32'hFFFFFFFC; flags[7] = 2'b01;
        insts[8] = 32'hFFF03093; ops[8] = 6'd18; imms[8] = 32'hFFFFFFFF; flags[8] = 2'b00;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if_valid = 1'b1; if_inst = insts[k];
            tick();
            if_valid = 1'b0;
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_to_rs !== 1'b1 || out_op !== ops[k] || out_imm !== imms[k]
                || {out_illegal, out_to_lsb} !== flags[k] || out_tag !== 4'(k)) begin
                n_fail++; $display("FAIL decode_%h got op=%0d imm=%h ill/lsb=%b tag=%0d exp op=%0d imm=%h ill/lsb=%b tag=%0d",
                                   insts[k], out_op, out_imm, {out_illegal, out_to_lsb}, out_tag,
                                   ops[k], imms[k], flags[k], k);
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        if_valid = 1'b1; if_inst = 32'hFFB00093;
        tick();
        if_valid = 1'b0;
        tick();
        rob_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_inst = 32'h002081B3;
            tick();
        end
        n_tests++;
        if (iq_count !== 3'd3) begin n_fail++; $display("FAIL clear_pre got cnt=%0d exp=3", iq_count); end
        clear = 1'b1; if_valid = 1'b1; rob_ready = 1'b1;
        #1;
        n_tests++;
        if (if_ready !== 1'b0) begin n_fail++; $display("FAIL clear_if_ready got=%b exp=0", if_ready); end
        tick();
        clear = 1'b0; if_valid = 1'b0;
        n_tests++;
        if (iq_count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_flush got cnt=%0d v=%b exp cnt=0 v=0", iq_count, out_valid);
        end
        if_valid = 1'b1; if_inst = 32'h002081B3;
        tick();
        if_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd0) begin
            n_fail++; $display("FAIL clear_tag got v=%b tag=%0d exp v=1 tag=0", out_valid, out_tag);
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        rdy_in = 1'b0; if_valid = 1'b1; if_inst = 32'hFFB00093;
        tick();
        n_tests++;
        if (iq_count !== 3'd0) begin n_fail++; $display("FAIL hold_no_enq got cnt=%0d exp=0", iq_count); end
        rdy_in = 1'b1;
        tick();
        if_valid = 1'b0;
        tick();
        rdy_in = 1'b0;
        tick(); tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_op !== 6'd10 || out_tag !== 4'd0) begin
            n_fail++; $display("FAIL hold_valid got v=%b op=%0d tag=%0d exp v=1 op=10 tag=0", out_valid, out_op, out_tag);
        end
        rdy_in = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got v=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        if_valid = 1'b1; if_inst = 32'hFFDFF0EF; if_pc = 32'h400;
        tick();
        if_inst = 32'hFFB00093;
        tick();
        if_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_op !== 6'd33 || out_imm !== 32'hFFFFFFFC || out_rd !== 5'd1 || iq_count !== 3'd1) begin
            n_fail++; $display("FAIL jal_dispatch got v=%b op=%0d imm=%h rd=%0d cnt=%0d exp op=33 imm=fffffffc rd=1 cnt=1",
                               out_valid, out_op, out_imm, out_rd, iq_count);
        end
        rob_ready = 1'b0;
        #3 rst_in = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_op !== 6'd37 || out_imm !== 32'd0 || out_pc !== 32'd0 || iq_count !== 3'd0) begin
            n_fail++; $display("FAIL async_reset got v=%b op=%0d imm=%h pc=%h cnt=%0d exp v=0 op=37 imm=0 pc=0 cnt=0",
                               out_valid, out_op, out_imm, out_pc, iq_count);
        end
        #1 rst_in = 1'b1;
        rob_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || iq_count !== 3'd0) begin
            n_fail++; $display("FAIL post_reset_idle got v=%b cnt=%0d exp v=0 cnt=0", out_valid, iq_count);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fill_drain();
        test_store_lsb();
        test_back_to_back();
        test_decode();
        test_clear();
        test_rdy_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
